// File: rtl/jtag_drv_pkg.sv
// Shared types and TMS constants for the JTAG host driver.
package jtag_drv_pkg;
  typedef enum logic [1:0] {
    OP_RESET    = 2'b00,
    OP_SHIFT_IR = 2'b01,
    OP_SHIFT_DR = 2'b10,
    OP_IDLE     = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {S_IDLE, S_TRST, S_HDR, S_SHIFT, S_TAIL, S_WAIT} drv_state_t;

  // TMS sequences, LSB goes out first
  localparam logic [2:0] DR_HDR  = 3'b001;
  localparam logic [3:0] IR_HDR  = 4'b0011;
  localparam logic [1:0] TAIL    = 2'b01;
  localparam logic [5:0] RST_TMS = 6'b011111;
endpackage

// File: rtl/jtag_tck_gen.sv
// tck divider: CLK_DIV cycles low then CLK_DIV high, with strobes in the last cycle of each phase.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic en,
  input  logic quiet,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = $clog2(2 * CLK_DIV);

  logic [CW-1:0] cnt;

  assign rise_stb = en && (cnt == CW'(CLK_DIV - 1));
  assign fall_stb = en && (cnt == CW'(2 * CLK_DIV - 1));

  // quiet keeps tck low while the period timing still runs
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= fall_stb ? '0 : cnt + CW'(1);
      if (rise_stb && !quiet) tck <= 1'b1;
      else if (fall_stb)      tck <= 1'b0;
    end
  end
endmodule

// File: rtl/jtag_host_driver.sv
// Command-driven JTAG host: each command runs Run-Test/Idle -> scan -> Run-Test/Idle.
// Define JTAG_DRV_TRST_EN to pulse trst ahead of the TMS reset sequence.
module jtag_host_driver
  import jtag_drv_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst,
  input  logic               tdo
);
  drv_state_t         state;
  cmd_op_t            op_q, op_in;
  logic [LW-1:0]      lm1_q, pcnt, len_sat, len_shift;
  logic [2:0]         hcnt, hlast_q;
  logic [5:0]         hdr_q;
  logic [MAX_LEN-1:0] sdata, cap;
  logic               en, quiet, fall_stb, rise_stb;

  assign op_in     = cmd_op_t'(cmd_op);
  assign len_sat   = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
  assign len_shift = (len_sat == '0) ? LW'(1) : len_sat;
  assign en        = (state != S_IDLE);
  assign quiet     = (state == S_TRST);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .sys_clk (sys_clk),
    .reset   (reset),
    .en      (en),
    .quiet   (quiet),
    .tck     (tck),
    .fall_stb(fall_stb),
    .rise_stb(rise_stb)
  );

`ifdef JTAG_DRV_TRST_EN
  logic trst_q;
  assign trst = ~reset & trst_q;
`else
  assign trst = ~reset;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_RESET;
      lm1_q     <= '0;
      pcnt      <= '0;
      hcnt      <= '0;
      hlast_q   <= '0;
      hdr_q     <= '0;
      sdata     <= '0;
      cap       <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef JTAG_DRV_TRST_EN
      trst_q    <= 1'b1;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q      <= op_in;
          sdata     <= cmd_data;
          cap       <= '0;
          hcnt      <= '0;
          pcnt      <= '0;
          tdi       <= 1'b0;
          cmd_ready <= 1'b0;
          case (op_in)
            OP_RESET: begin
              hdr_q   <= RST_TMS;
              hlast_q <= 3'd5;
              tms     <= 1'b1;
`ifdef JTAG_DRV_TRST_EN
              state   <= S_TRST;
              trst_q  <= 1'b0;
`else
              state   <= S_HDR;
`endif
            end
            OP_SHIFT_IR: begin
              hdr_q   <= {2'b00, IR_HDR};
              hlast_q <= 3'd3;
              tms     <= IR_HDR[0];
              lm1_q   <= len_shift - LW'(1);
              state   <= S_HDR;
            end
            OP_SHIFT_DR: begin
              hdr_q   <= {3'b000, DR_HDR};
              hlast_q <= 3'd2;
              tms     <= DR_HDR[0];
              lm1_q   <= len_shift - LW'(1);
              state   <= S_HDR;
            end
            OP_IDLE: begin
              // zero-length idle completes without leaving S_IDLE
              if (len_sat == '0) begin
                rsp_valid <= 1'b1;
                cmd_ready <= 1'b1;
                rsp_data  <= '0;
              end else begin
                tms   <= 1'b0;
                lm1_q <= len_sat - LW'(1);
                state <= S_WAIT;
              end
            end
          endcase
        end
        S_TRST: if (fall_stb) begin
          if (hcnt == 3'd1) begin
            hcnt   <= '0;
            state  <= S_HDR;
`ifdef JTAG_DRV_TRST_EN
            trst_q <= 1'b1;
`endif
          end else begin
            hcnt <= hcnt + 3'd1;
          end
        end
        S_HDR: if (fall_stb) begin
          if (hcnt == hlast_q) begin
            hcnt <= '0;
            if (op_q == OP_RESET) begin
              state     <= S_IDLE;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state <= S_SHIFT;
              tms   <= (lm1_q == '0);
              tdi   <= sdata[0];
            end
          end else begin
            hcnt  <= hcnt + 3'd1;
            hdr_q <= hdr_q >> 1;
            tms   <= hdr_q[1];
          end
        end
        S_SHIFT: begin
          if (rise_stb) cap <= {tdo, cap[MAX_LEN-1:1]};
          if (fall_stb) begin
            if (pcnt == lm1_q) begin
              state <= S_TAIL;
              tms   <= TAIL[0];
              tdi   <= 1'b0;
            end else begin
              pcnt  <= pcnt + LW'(1);
              tms   <= (pcnt + LW'(1) == lm1_q);
              tdi   <= sdata[1];
              sdata <= sdata >> 1;
            end
          end
        end
        S_TAIL: if (fall_stb) begin
          if (hcnt == 3'd1) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b1;
            cmd_ready <= 1'b1;
            // first captured bit sits at MAX_LEN-1-lm1 after the shifts
            rsp_data  <= cap >> (MAX_LEN - 1 - int'(lm1_q));
          end else begin
            hcnt <= 3'd1;
            tms  <= TAIL[1];
          end
        end
        S_WAIT: if (fall_stb) begin
          if (pcnt == lm1_q) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b1;
            cmd_ready <= 1'b1;
            rsp_data  <= '0;
          end else begin
            pcnt <= pcnt + LW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_host_driver.sv
// Self-checking bench for jtag_host_driver with a behavioural IEEE 1149.1 TAP model.
module tb_jtag_host_driver;
  localparam int CD = 2;
  localparam int ML = 32;
  localparam int LW = $clog2(ML + 1);
  localparam logic [31:0] IDCODE = 32'h1234_5679;
  localparam logic [3:0]  I_IDC  = 4'h1;
`ifdef JTAG_DRV_TRST_EN
  localparam int TRST_CYC = 4 * CD;
`else
  localparam int TRST_CYC = 0;
`endif

  logic          sys_clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, tdo = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [ML-1:0] cmd_data = '0;
  logic          cmd_ready, rsp_valid, tck, tms, tdi, trst;
  logic [ML-1:0] rsp_data;

  int total = 0, bad = 0;
  logic [3:0] cur_ir = I_IDC;

  jtag_host_driver #(.CLK_DIV(CD), .MAX_LEN(ML)) dut (
    .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- behavioural TAP ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR} tap_t;
  tap_t tap_st = TLR;
  logic [3:0]  tap_ir = I_IDC, ir_sr = '0;
  logic [31:0] dr_sr = '0;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PSDR;
      PSDR:  return m ? EX2DR : PSDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PSIR;
      PSIR:  return m ? EX2IR : PSIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap_st <= TLR;
      tap_ir <= I_IDC;
    end else begin
      case (tap_st)
        TLR:   tap_ir <= I_IDC;
        CAPDR: dr_sr  <= (tap_ir == I_IDC) ? IDCODE : 32'h0;
        SHDR:  if (tap_ir == I_IDC) dr_sr <= {tdi, dr_sr[31:1]};
               else dr_sr[0] <= tdi;
        CAPIR: ir_sr  <= 4'b0101;
        SHIR:  ir_sr  <= {tdi, ir_sr[3:1]};
        UPIR:  tap_ir <= ir_sr;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck) begin
    if (tap_st == SHDR) tdo <= dr_sr[0];
    else if (tap_st == SHIR) tdo <= ir_sr[0];
  end

  // ---------------- monitors ----------------
  bit tms_q[$], tdi_q[$];
  always @(posedge tck) begin
    tms_q.push_back(tms);
    tdi_q.push_back(tdi);
  end

  int viol = 0;
  logic ptck = 1'b0, ptms = 1'b0, ptdi = 1'b0;
  always @(negedge sys_clk) begin
    if (ptck && tck && (tms !== ptms || tdi !== ptdi)) viol <= viol + 1;
    ptck <= tck; ptms <= tms; ptdi <= tdi;
  end

  // ---------------- reference helpers ----------------
  function automatic int eff_len(int op, int len);
    int l = (len > ML) ? ML : len;
    if ((op == 1 || op == 2) && l == 0) l = 1;
    return l;
  endfunction

  function automatic logic [31:0] lmask(int l);
    logic [63:0] m = (64'd1 << l) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] exp_dr(int len, logic [31:0] d);
    int l = eff_len(2, len);
    return (cur_ir == I_IDC) ? (IDCODE & lmask(l)) : ((d << 1) & lmask(l));
  endfunction

  // issues one command from a point just after a rising edge, returns in the rsp_valid cycle
  task automatic do_cmd(input int op, input int len, input logic [31:0] d,
                        input logic [31:0] er, input string nm);
    int L, n, lat, cyc, tlo, i0, emis;
    bit et[$];
    bit ed[$];
    L = eff_len(op, len);
    case (op)
      0: begin
        for (int i = 0; i < 6; i++) begin et.push_back(i < 5); ed.push_back(1'b0); end
      end
      3: for (int i = 0; i < L; i++) begin et.push_back(1'b0); ed.push_back(1'b0); end
      default: begin
        if (op == 1) begin et.push_back(1'b1); ed.push_back(1'b0); end
        et.push_back(1'b1); et.push_back(1'b0); et.push_back(1'b0);
        for (int i = 0; i < 3; i++) ed.push_back(1'b0);
        for (int i = 0; i < L; i++) begin et.push_back(i == L - 1); ed.push_back(d[i]); end
        et.push_back(1'b1); et.push_back(1'b0); ed.push_back(1'b0); ed.push_back(1'b0);
      end
    endcase
    n   = et.size();
    lat = n * 2 * CD + 1 + ((op == 0) ? TRST_CYC : 0);

    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s pre_ready got=%b exp=1", nm, cmd_ready); end
    i0 = tms_q.size();
    cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_len = len[LW-1:0]; cmd_data = d;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    cyc = 1; tlo = 0;
    if (n > 0) begin
      total++;
      if (cmd_ready !== 1'b0 || tck !== 1'b0) begin
        bad++; $display("FAIL %s busy ready=%b tck=%b exp ready=0 tck=0", nm, cmd_ready, tck);
      end
    end
    while (rsp_valid !== 1'b1 && cyc < 2000) begin
      if (trst === 1'b0) tlo++;
      @(posedge sys_clk); #1;
      cyc++;
    end
    total++;
    if (cyc != lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, cyc, lat); end
    total++;
    if (rsp_data !== er) begin bad++; $display("FAIL %s rsp_data got=%h exp=%h", nm, rsp_data, er); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s ready_at_rsp got=%b exp=1", nm, cmd_ready); end
    total++;
    if (tms_q.size() - i0 != n) begin
      bad++; $display("FAIL %s tck_pulses got=%0d exp=%0d", nm, tms_q.size() - i0, n);
    end else begin
      emis = 0;
      for (int i = 0; i < n; i++)
        if (tms_q[i0+i] != et[i] || tdi_q[i0+i] != ed[i]) emis++;
      total++;
      if (emis != 0) begin bad++; $display("FAIL %s tms_tdi_seq wrong_periods=%0d exp=0", nm, emis); end
    end
    total++;
    if (tlo != ((op == 0) ? TRST_CYC : 0)) begin
      bad++; $display("FAIL %s trst_low got=%0d exp=%0d", nm, tlo, (op == 0) ? TRST_CYC : 0);
    end
    total++;
    if (tap_st != RTI) begin bad++; $display("FAIL %s tap_end got=%0d exp=%0d", nm, tap_st, RTI); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    total++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, trst} !== 6'b010100 || rsp_data !== '0) begin
      bad++; $display("FAIL reset_during tck,tms,tdi,rdy,vld,trst=%b%b%b%b%b%b exp=010100 data=%h",
                      tck, tms, tdi, cmd_ready, rsp_valid, trst, rsp_data);
    end
    reset = 1'b0;
    @(posedge sys_clk); #1;
    total++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, trst} !== 6'b010101 || rsp_data !== '0) begin
      bad++; $display("FAIL reset_after tck,tms,tdi,rdy,vld,trst=%b%b%b%b%b%b exp=010101 data=%h",
                      tck, tms, tdi, cmd_ready, rsp_valid, trst, rsp_data);
    end
  endtask

  task automatic test_reset_op;
    do_cmd(0, 0, 32'h0, 32'h0, "reset_op");
    cur_ir = I_IDC;
  endtask

  task automatic test_shift_ir;
    do_cmd(1, 4, 32'h1, 32'h5, "shift_ir");
    cur_ir = 4'h1;
    total++;
    if (tap_ir !== 4'h1) begin bad++; $display("FAIL shift_ir tap_ir got=%h exp=1", tap_ir); end
  endtask

  task automatic test_shift_dr;
    do_cmd(2, 32, $urandom, IDCODE, "idcode");
    do_cmd(2, 0, 32'h0, 32'h1, "dr_len0");
    do_cmd(2, 40, $urandom, IDCODE, "dr_sat");
    do_cmd(1, 4, 32'hF, 32'h5, "ir_bypass");
    cur_ir = 4'hF;
    do_cmd(2, 8, 32'hA5, 32'h4A, "bypass");
  endtask

  task automatic test_idle;
    do_cmd(3, 0, 32'h0, 32'h0, "idle0");
    do_cmd(3, 3, 32'h0, 32'h0, "idle3");
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    do_cmd(3, 2, 32'h0, 32'h0, "b2b_first");
    d = $urandom;
    do_cmd(2, 8, d, exp_dr(8, d), "b2b_second");
  endtask

  task automatic test_random;
    int op, len;
    logic [31:0] d, er;
    for (int k = 0; k < 16; k++) begin
      op = $urandom_range(3, 1);
      d  = $urandom;
      case (op)
        1: begin
          len = $urandom_range(8, 4);
          er  = (32'h5 | (d << 4)) & lmask(len);
          do_cmd(1, len, d, er, "rand_ir");
          cur_ir = 4'((d >> (len - 4)) & 32'hF);
        end
        2: begin
          len = $urandom_range(40, 0);
          do_cmd(2, len, d, exp_dr(len, d), "rand_dr");
        end
        default: begin
          len = $urandom_range(5, 0);
          do_cmd(3, len, d, 32'h0, "rand_idle");
        end
      endcase
    end
  endtask

  task automatic test_reset_mid;
    int cyc, i0, seen;
    i0 = tms_q.size();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = LW'(32); cmd_data = $urandom;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (tms_q.size() - i0 < 10 && cyc < 500) begin @(posedge sys_clk); #1; cyc++; end
    total++;
    if (tms_q.size() - i0 < 10) begin bad++; $display("FAIL reset_mid reach_period10 got=%0d exp=10", tms_q.size() - i0); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, trst} !== 6'b010100) begin
      bad++; $display("FAIL reset_mid outputs tck,tms,tdi,rdy,vld,trst=%b%b%b%b%b%b exp=010100",
                      tck, tms, tdi, cmd_ready, rsp_valid, trst);
    end
    seen = 0;
    repeat (4) begin @(posedge sys_clk); #1; if (rsp_valid !== 1'b0) seen++; end
    reset = 1'b0;
    repeat (200) begin @(posedge sys_clk); #1; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || tck !== 1'b0) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_mid quiet_after bad_cycles=%0d exp=0", seen); end
    test_reset_op();
    do_cmd(2, 32, 32'h0, IDCODE, "idcode_after_reset");
  endtask

  initial begin
    test_reset();
    test_reset_op();
    test_shift_ir();
    test_shift_dr();
    test_idle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    total++;
    if (viol != 0) begin bad++; $display("FAIL tms_tdi_stable_high changes=%0d exp=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
